// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter_if : fetch port, data port and mem_system signals of mem_arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
interface mem_arbiter_if;
  logic        i_rd;
  logic [15:0] i_addr;
  logic [15:0] i_data_out;
  logic        i_done;
  logic        i_stall;
  logic        i_hit;
  logic        i_err;

  logic        d_rd;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_data_in;
  logic [15:0] d_data_out;
  logic        d_done;
  logic        d_stall;
  logic        d_hit;
  logic        d_err;

  logic [15:0] m_addr;
  logic [15:0] m_data_in;
  logic        m_rd;
  logic        m_wr;
  logic [15:0] m_data_out;
  logic        m_done;
  logic        m_hit;
  logic        m_err;

  logic [1:0]  grant;

  // Environment side: the two requesters plus mem_system.
  modport master (
    output i_rd, i_addr, d_rd, d_wr, d_addr, d_data_in,
           m_data_out, m_done, m_hit, m_err,
    input  i_data_out, i_done, i_stall, i_hit, i_err,
           d_data_out, d_done, d_stall, d_hit, d_err,
           m_addr, m_data_in, m_rd, m_wr, grant
  );

  // Arbiter side.
  modport slave (
    input  i_rd, i_addr, d_rd, d_wr, d_addr, d_data_in,
           m_data_out, m_done, m_hit, m_err,
    output i_data_out, i_done, i_stall, i_hit, i_err,
           d_data_out, d_done, d_stall, d_hit, d_err,
           m_addr, m_data_in, m_rd, m_wr, grant
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter : shares one mem_system between the I-fetch and data ports
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int DATA_PRI = 0,
  parameter int TIMEOUT  = 64
) (
  input  wire logic   clk,
  input  wire logic   rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       last_d;
  logic [7:0] tmo_cnt;

  logic i_req;
  logic d_req;
  logic pick_d;
  logic own_i;
  logic own_d;
  logic timed_out;
  logic finish;

  // Simultaneous rd and wr on the data port is not a request.
  assign i_req  = bus.i_rd;
  assign d_req  = bus.d_rd ^ bus.d_wr;
  assign pick_d = d_req & (~i_req | (DATA_PRI != 0) | ~last_d);

  assign own_i     = (state == GNT_I);
  assign own_d     = (state == GNT_D);
  assign timed_out = (own_i | own_d) & ~bus.m_done & (tmo_cnt == TMO_LAST);
  assign finish    = (own_i | own_d) & (bus.m_done | timed_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.grant     <= 2'b00;
      bus.m_addr    <= 16'h0000;
      bus.m_data_in <= 16'h0000;
      bus.m_rd      <= 1'b0;
      bus.m_wr      <= 1'b0;
      last_d        <= 1'b1;
      tmo_cnt       <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req | d_req) begin
            state         <= pick_d ? GNT_D : GNT_I;
            bus.grant     <= pick_d ? 2'b10 : 2'b01;
            bus.m_addr    <= pick_d ? bus.d_addr : bus.i_addr;
            bus.m_data_in <= pick_d ? bus.d_data_in : 16'h0000;
            bus.m_rd      <= pick_d ? bus.d_rd : 1'b1;
            bus.m_wr      <= pick_d & bus.d_wr;
            tmo_cnt       <= 8'd0;
          end
        end
        default: begin
          // Always pass through IDLE so mem_system never sees back-to-back issue.
          if (finish) begin
            state     <= IDLE;
            bus.grant <= 2'b00;
            bus.m_rd  <= 1'b0;
            bus.m_wr  <= 1'b0;
            last_d    <= own_d;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  assign bus.i_done     = own_i & finish;
  assign bus.i_data_out = own_i ? bus.m_data_out : 16'h0000;
  assign bus.i_hit      = own_i & bus.m_done & bus.m_hit;
  assign bus.i_err      = own_i & (bus.m_done ? bus.m_err : timed_out);
  assign bus.i_stall    = bus.i_rd & ~bus.i_done;

  assign bus.d_done     = own_d & finish;
  assign bus.d_data_out = own_d ? bus.m_data_out : 16'h0000;
  assign bus.d_hit      = own_d & bus.m_done & bus.m_hit;
  assign bus.d_err      = own_d & (bus.m_done ? bus.m_err : timed_out);
  assign bus.d_stall    = (bus.d_rd | bus.d_wr) & ~bus.d_done;
endmodule
`default_nettype wire
